// File: rtl/gs_host_master.sv
// General Sound host-side bus initiator: optional data write to #B3, command write to #BB,
// status polling at #BB and an optional response read from #B3, one transaction at a time.
`timescale 1ns/1ps
module gs_host_master #(
  parameter int T_SETUP    = 2,
  parameter int T_STROBE   = 8,
  parameter int T_HOLD     = 2,
  parameter int POLL_LIMIT = 1023
) (
  input  logic        clk32,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic        cmd_has_data,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_want_resp,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  output logic        resp_err,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        n_iorq,
  output logic        n_rd,
  output logic        n_wr,
  output logic        n_m1,
  output logic        n_mreq
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_DATA   = 3'd1;
  localparam logic [2:0] S_WR_CMD    = 3'd2;
  localparam logic [2:0] S_POLL_CMD  = 3'd3;
  localparam logic [2:0] S_POLL_DATA = 3'd4;
  localparam logic [2:0] S_RD_DATA   = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [1:0] PH_GAP    = 2'd0;
  localparam logic [1:0] PH_SETUP  = 2'd1;
  localparam logic [1:0] PH_STROBE = 2'd2;
  localparam logic [1:0] PH_HOLD   = 2'd3;

  localparam int CNT_W = $clog2(T_SETUP + T_STROBE + T_HOLD + 1);
  localparam int PC_W  = $clog2(POLL_LIMIT + 1);

  localparam logic [15:0] PORT_DATA = 16'h00B3;
  localparam logic [15:0] PORT_CMD  = 16'h00BB;

  logic [2:0]       state;
  logic [1:0]       phase;
  logic [CNT_W-1:0] cnt;
  logic [PC_W-1:0]  poll_cnt;

  logic [7:0]  req_code;
  logic [7:0]  req_data;
  logic        req_want_resp;
  logic [15:0] a_r;
  logic [7:0]  d_r;
  logic [7:0]  rd_byte;

  logic        is_write;
  logic        is_poll;
  logic        is_bus;
  logic [15:0] bus_addr;
  logic        last_setup;
  logic        last_strobe;
  logic        last_hold;
  logic        status_ok;
  logic        poll_exhausted;

  always_comb begin
    is_write       = (state == S_WR_DATA) || (state == S_WR_CMD);
    is_poll        = (state == S_POLL_CMD) || (state == S_POLL_DATA);
    is_bus         = is_write || is_poll || (state == S_RD_DATA);
    bus_addr       = ((state == S_WR_DATA) || (state == S_RD_DATA)) ? PORT_DATA : PORT_CMD;
    last_setup     = (cnt == CNT_W'(T_SETUP - 1));
    last_strobe    = (cnt == CNT_W'(T_STROBE - 1));
    last_hold      = (cnt == CNT_W'(T_HOLD - 1));
    // Command poll waits for the busy flag to clear; data poll waits for the data flag to set.
    status_ok      = (state == S_POLL_CMD) ? ~rd_byte[0] : rd_byte[7];
    poll_exhausted = (poll_cnt == PC_W'(POLL_LIMIT));
  end

  assign cmd_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign a          = a_r;
  assign d_out      = d_r;
  assign d_oe       = is_write && (phase != PH_GAP);
  assign n_iorq     = ~(is_bus && (phase == PH_STROBE));
  assign n_rd       = ~(is_bus && !is_write && (phase == PH_STROBE));
  assign n_wr       = ~(is_write && (phase == PH_STROBE));
  assign n_m1       = 1'b1;
  assign n_mreq     = 1'b1;

  always_ff @(posedge clk32) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= PH_GAP;
      cnt       <= '0;
      poll_cnt  <= '0;
      a_r       <= '0;
      d_r       <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            req_code      <= cmd_code;
            req_data      <= cmd_data;
            req_want_resp <= cmd_want_resp;
            state         <= cmd_has_data ? S_WR_DATA : S_WR_CMD;
            phase         <= PH_GAP;
            cnt           <= '0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_WR_DATA, S_WR_CMD, S_POLL_CMD, S_POLL_DATA, S_RD_DATA: begin
          case (phase)
            // gap -> setup: present address (and write data) ahead of the strobes
            PH_GAP: begin
              phase <= PH_SETUP;
              cnt   <= '0;
              a_r   <= bus_addr;
              if (is_write) d_r <= (state == S_WR_DATA) ? req_data : req_code;
            end
            PH_SETUP: begin
              if (last_setup) begin
                phase <= PH_STROBE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            // strobe -> hold: read data is captured on the final strobe clock
            PH_STROBE: begin
              if (last_strobe) begin
                phase <= PH_HOLD;
                cnt   <= '0;
                if (!is_write) rd_byte <= d_in;
                if (is_poll) poll_cnt <= poll_cnt + 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            // hold -> gap: decide the next bus cycle or completion
            PH_HOLD: begin
              if (last_hold) begin
                phase <= PH_GAP;
                cnt   <= '0;
                case (state)
                  S_WR_DATA: state <= S_WR_CMD;
                  S_WR_CMD: begin
                    state    <= S_POLL_CMD;
                    poll_cnt <= '0;
                  end
                  S_POLL_CMD: begin
                    if (status_ok) begin
                      if (req_want_resp) begin
                        state    <= S_POLL_DATA;
                        poll_cnt <= '0;
                      end else begin
                        state     <= S_DONE;
                        resp_data <= 8'h00;
                        resp_err  <= 1'b0;
                      end
                    end else if (poll_exhausted) begin
                      state     <= S_DONE;
                      resp_data <= 8'h00;
                      resp_err  <= 1'b1;
                    end
                  end
                  S_POLL_DATA: begin
                    if (status_ok) begin
                      state <= S_RD_DATA;
                    end else if (poll_exhausted) begin
                      state     <= S_DONE;
                      resp_data <= 8'h00;
                      resp_err  <= 1'b1;
                    end
                  end
                  S_RD_DATA: begin
                    state     <= S_DONE;
                    resp_data <= rd_byte;
                    resp_err  <= 1'b0;
                  end
                  default: state <= S_IDLE;
                endcase
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          endcase
        end
        default: begin
          state <= S_IDLE;
          phase <= PH_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gs_host_master.sv
// Randomized bench for gs_host_master: a scripted GS responder on the I/O bus and a
// transaction-level model of the expected bus accesses and response.
`timescale 1ns/1ps
module tb_gs_host_master;

  localparam int T_SETUP    = 2;
  localparam int T_STROBE   = 8;
  localparam int T_HOLD     = 2;
  localparam int POLL_LIMIT = 4;
  localparam int CYC_PERIOD = T_SETUP + T_STROBE + T_HOLD + 1;

  logic        clk32 = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_code;
  logic        cmd_has_data;
  logic [7:0]  cmd_data;
  logic        cmd_want_resp;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        resp_err;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in = 8'h00;
  logic        n_iorq, n_rd, n_wr, n_m1, n_mreq;

  always #5 clk32 = ~clk32;

  gs_host_master #(
    .T_SETUP(T_SETUP), .T_STROBE(T_STROBE), .T_HOLD(T_HOLD), .POLL_LIMIT(POLL_LIMIT)
  ) dut (
    .clk32(clk32), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_has_data(cmd_has_data), .cmd_data(cmd_data), .cmd_want_resp(cmd_want_resp),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .a(a), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
    .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .n_m1(n_m1), .n_mreq(n_mreq)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
    int          width;
    bit          setup_ok;
    bit          hold_ok;
  } bus_ev_t;

  bus_ev_t log_q[$];
  bus_ev_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // responder script: bit0 busy for rb_busy status reads after a command write,
  // bit7 set once rb_nodata further reads have returned it clear
  int          rb_busy = 0;
  int          rb_nodata = 0;
  logic [7:0]  rb_byte = 8'h00;
  int          st_reads = 0;

  bit          mon_en = 1'b0;
  int          cyc = 0;
  bit          prev_stb = 1'b0;
  int          hold_left = 0;
  bit          post = 1'b0;
  bus_ev_t     cur;
  logic [15:0] ha [8];
  bit          ho [8];
  bit          hs [8];
  int          inv_bad = 0;
  int          resp_seen = 0;

  always @(negedge clk32) begin
    bit         stb;
    bit         ok;
    logic [7:0] sv;
    cyc++;
    stb = !n_iorq;
    if (mon_en) begin
      if (!n_rd && !n_wr) inv_bad++;
      if (!n_rd && d_oe) inv_bad++;
      if (n_iorq && (!n_rd || !n_wr)) inv_bad++;
      if (!n_m1 || !n_mreq) inv_bad++;
      if (resp_valid) resp_seen++;
      if (stb && !prev_stb) begin
        cur.wr      = !n_wr;
        cur.addr    = a;
        cur.data    = cur.wr ? d_out : 8'h00;
        cur.cyc     = cyc;
        cur.width   = 0;
        cur.hold_ok = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < T_SETUP; k++)
          if (ha[k] !== a || ho[k] !== cur.wr || !hs[k]) ok = 1'b0;
        if (ho[T_SETUP] || !hs[T_SETUP]) ok = 1'b0;
        cur.setup_ok = ok;
        if (!cur.wr) begin
          if (a == 16'h00BB) begin
            sv    = 8'($urandom);
            sv[0] = (st_reads < rb_busy);
            sv[7] = (st_reads >= rb_busy + 1 + rb_nodata);
            d_in  = sv;
            st_reads++;
          end else if (a == 16'h00B3) begin
            d_in = rb_byte;
          end else begin
            d_in = 8'($urandom);
          end
        end else if (a == 16'h00BB) begin
          st_reads = 0;
        end
      end
      if (stb) cur.width++;
      if (!stb && prev_stb) begin
        hold_left = T_HOLD;
        d_in = 8'($urandom);
      end
      if (hold_left > 0) begin
        if (a !== cur.addr || d_oe !== cur.wr || (cur.wr && d_out !== cur.data)) cur.hold_ok = 1'b0;
        hold_left--;
        if (hold_left == 0) post = 1'b1;
      end else if (post) begin
        if (d_oe || !n_iorq) cur.hold_ok = 1'b0;
        post = 1'b0;
        log_q.push_back(cur);
      end
    end
    for (int k = 7; k > 0; k--) begin
      ha[k] = ha[k-1];
      ho[k] = ho[k-1];
      hs[k] = hs[k-1];
    end
    ha[0] = a;
    ho[0] = d_oe;
    hs[0] = n_iorq;
    prev_stb = stb;
  end

  task automatic push_ev(input bit wr, input logic [15:0] addr, input logic [7:0] data);
    bus_ev_t e;
    e.wr = wr; e.addr = addr; e.data = data;
    e.cyc = 0; e.width = T_STROBE; e.setup_ok = 1'b1; e.hold_ok = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic model(input bit hd, input logic [7:0] dt, input logic [7:0] cd, input bit wt,
                       input int nb, input int nn, input logic [7:0] rb,
                       output bit err, output logic [7:0] rdata);
    exp_q.delete();
    err = 1'b0;
    rdata = 8'h00;
    if (hd) push_ev(1'b1, 16'h00B3, dt);
    push_ev(1'b1, 16'h00BB, cd);
    if (nb + 1 > POLL_LIMIT) begin
      repeat (POLL_LIMIT) push_ev(1'b0, 16'h00BB, 8'h00);
      err = 1'b1;
    end else begin
      repeat (nb + 1) push_ev(1'b0, 16'h00BB, 8'h00);
      if (wt) begin
        if (nn + 1 > POLL_LIMIT) begin
          repeat (POLL_LIMIT) push_ev(1'b0, 16'h00BB, 8'h00);
          err = 1'b1;
        end else begin
          repeat (nn + 1) push_ev(1'b0, 16'h00BB, 8'h00);
          push_ev(1'b0, 16'h00B3, 8'h00);
          rdata = rb;
        end
      end
    end
  endtask

  task automatic start_txn(input bit hd, input logic [7:0] dt, input logic [7:0] cd,
                           input bit wt, input bit keep, input string tag);
    bit acc;
    acc = 1'b0;
    @(negedge clk32);
    cmd_has_data  = hd;
    cmd_data      = dt;
    cmd_code      = cd;
    cmd_want_resp = wt;
    cmd_valid     = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk32);
    end
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    @(posedge clk32);
    #1;
    if (!keep) cmd_valid = 1'b0;
    chk({tag, "_rdy_drop"}, 32'(cmd_ready), 32'd0);
  endtask

  task automatic finish_txn(input bit exp_err, input logic [7:0] exp_data, input int base,
                            input string tag);
    bit      got;
    int      early;
    bus_ev_t g;
    got = 1'b0;
    early = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk32);
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      if (cmd_ready) early++;
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_busy_ready"}, 32'(early), 32'd0);
    #1;
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, "_data"}, 32'(resp_data), 32'(exp_data));
    chk({tag, "_nbus"}, 32'(log_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
      g = log_q[base + i];
      chk($sformatf("%s_wr%0d", tag, i), 32'(g.wr), 32'(exp_q[i].wr));
      chk($sformatf("%s_addr%0d", tag, i), 32'(g.addr), 32'(exp_q[i].addr));
      if (exp_q[i].wr) chk($sformatf("%s_wdata%0d", tag, i), 32'(g.data), 32'(exp_q[i].data));
      chk($sformatf("%s_width%0d", tag, i), 32'(g.width), 32'(T_STROBE));
      chk($sformatf("%s_setup%0d", tag, i), 32'(g.setup_ok), 32'd1);
      chk($sformatf("%s_hold%0d", tag, i), 32'(g.hold_ok), 32'd1);
      if (i > 0)
        chk($sformatf("%s_space%0d", tag, i), 32'(g.cyc - log_q[base + i - 1].cyc), 32'(CYC_PERIOD));
    end
    @(negedge clk32);
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_data_hold"}, 32'(resp_data), 32'(exp_data));
  endtask

  task automatic do_txn(input bit hd, input logic [7:0] dt, input logic [7:0] cd, input bit wt,
                        input int nb, input int nn, input logic [7:0] rb, input string tag);
    bit         e_err;
    logic [7:0] e_data;
    int         base;
    rb_busy   = nb;
    rb_nodata = nn;
    rb_byte   = rb;
    model(hd, dt, cd, wt, nb, nn, rb, e_err, e_data);
    base = log_q.size();
    start_txn(hd, dt, cd, wt, 1'b0, tag);
    finish_txn(e_err, e_data, base, tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         e_err;
    logic [7:0] e_data;
    int         base;
    int         seen0;
    bit         hit;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_code = 8'h00;
    cmd_has_data = 1'b0;
    cmd_data = 8'h00;
    cmd_want_resp = 1'b0;
    repeat (3) @(posedge clk32);
    @(negedge clk32);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_d_out", 32'(d_out), 32'd0);
    chk("rst_d_oe", 32'(d_oe), 32'd0);
    chk("rst_strobes", 32'({n_iorq, n_rd, n_wr, n_m1, n_mreq}), 32'h1F);
    mon_en = 1'b1;
    rst = 1'b0;

    do_txn(1'b1, 8'h5A, 8'h01, 1'b0, 0, 0, 8'h00, "t1");
    do_txn(1'b0, 8'h00, 8'h10, 1'b1, 2, 1, 8'hC3, "t2");
    do_txn(1'b0, 8'h00, 8'h20, 1'b0, 100, 0, 8'h00, "to_cmd");
    do_txn(1'b1, 8'h11, 8'h21, 1'b1, 0, 100, 8'h77, "to_data");
    do_txn(1'b0, 8'h00, 8'h22, 1'b0, POLL_LIMIT - 1, 0, 8'h00, "last_cmd");
    do_txn(1'b0, 8'h00, 8'h23, 1'b1, 1, POLL_LIMIT - 1, 8'h9E, "last_data");

    // reset while the command write is strobing
    rb_busy = 0; rb_nodata = 0; rb_byte = 8'h00;
    seen0 = resp_seen;
    start_txn(1'b0, 8'h00, 8'h33, 1'b0, 1'b0, "rmid");
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk32);
      if (!n_wr && a == 16'h00BB) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rmid_strobe_seen", 32'(hit), 32'd1);
    repeat (2) @(negedge clk32);
    rst = 1'b1;
    @(posedge clk32);
    #1;
    chk("rmid_strobes", 32'({n_iorq, n_rd, n_wr}), 32'h7);
    chk("rmid_d_oe", 32'(d_oe), 32'd0);
    chk("rmid_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk32);
    rst = 1'b0;
    repeat (6) @(negedge clk32);
    chk("rmid_no_resp", 32'(resp_seen - seen0), 32'd0);
    do_txn(1'b1, 8'hA5, 8'h34, 1'b1, 1, 2, 8'h3C, "after_rst");

    // back-to-back with cmd_valid held high
    rb_busy = 1; rb_nodata = 0; rb_byte = 8'h4D;
    model(1'b1, 8'h66, 8'h40, 1'b1, 1, 0, 8'h4D, e_err, e_data);
    base = log_q.size();
    start_txn(1'b1, 8'h66, 8'h40, 1'b1, 1'b1, "b2b_a");
    cmd_has_data  = 1'b0;
    cmd_code      = 8'h41;
    cmd_want_resp = 1'b0;
    finish_txn(e_err, e_data, base, "b2b_a");
    model(1'b0, 8'h00, 8'h41, 1'b0, 1, 0, 8'h4D, e_err, e_data);
    base = log_q.size();
    @(posedge clk32);
    #1;
    cmd_valid = 1'b0;
    chk("b2b_b_rdy_drop", 32'(cmd_ready), 32'd0);
    finish_txn(e_err, e_data, base, "b2b_b");

    for (int t = 0; t < 24; t++) begin
      do_txn(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 8'($urandom),
             $sformatf("rnd%0d", t));
    end

    chk("bus_invariants", 32'(inv_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
